alu_sched: RTL and testbench
============================

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter NREQ, default 2, meaning the number of requesters (legal values 2..4).
REQ-002 SHALL have parameter W, default 8, meaning the operand and result width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ bits: per-requester command valid.
REQ-006 SHALL have port req_ready, output, NREQ bits: per-requester accept; at most one bit high.
REQ-007 SHALL have port req_a, input, NREQ*W bits: operand a per requester, slot i at [i*W +: W].
REQ-008 SHALL have port req_b, input, NREQ*W bits: operand b per requester, same packing as req_a.
REQ-009 SHALL have port req_op, input, NREQ*3 bits: operation per requester, slot i at [i*3 +: 3].
REQ-010 SHALL have port rsp_valid, output, 1 bit: result valid.
REQ-011 SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port rsp_id, output, clog2(NREQ) bits: index of the requester that issued the result.
REQ-013 SHALL have port rsp_out, output, W bits: the result.
REQ-014 SHALL have port rsp_carry, output, 1 bit: carry or borrow.
REQ-015 SHALL have port rsp_err, output, 1 bit: illegal opcode.

Function
REQ-016 SHALL implement the opcodes 0 ADD, 1 SUB, 2 XOR, 3 OR and 4 AND on W-bit operands; results wrap modulo 2^W.
REQ-017 SHALL drive rsp_carry as follows: ADD gives bit W of the (W+1)-bit sum; SUB gives 1 when a<b unsigned; every logic op gives 0.
REQ-018 SHALL treat opcodes 5-7 as illegal: rsp_out=0, rsp_carry=0, rsp_err=1; the command is still accepted and answered.
REQ-019 SHALL run an FSM with two states: IDLE (output register empty) and RESP (rsp_valid=1).
REQ-020 SHALL define the accept window as state IDLE, or state RESP with rsp_ready=1.
REQ-021 SHALL, in the accept window with any req_valid high, assert exactly one req_ready combinationally, for the arbitration winner.
REQ-022 SHALL never assert any req_ready outside the accept window.
REQ-023 SHALL complete a transfer on req_valid[i] & req_ready[i], registering the result, carry, err and id at that edge.
REQ-024 SHALL enter RESP after every transfer, giving a latency of 1 cycle from accept to rsp_valid.
REQ-025 SHALL, in RESP with rsp_ready=1 and no request, return to IDLE.
REQ-026 SHALL, in RESP with rsp_ready=0, hold all rsp_* outputs stable.
REQ-027 SHALL sustain a throughput of 1 result per cycle with back-to-back accepts while rsp_ready=1.
REQ-028 SHALL arbitrate round-robin: search starts at last_grant+1 modulo NREQ; last_grant updates only on a transfer.
REQ-029 SHALL accept a requester's command while its req_valid is high even if its fields change; a requester SHALL hold its fields stable until it is accepted.

Reset
REQ-030 SHALL, with rst high, force state IDLE, rsp_valid=0, rsp_out=0, rsp_carry=0, rsp_err=0, rsp_id=0, last_grant=NREQ-1 (requester 0 is first), and req_ready=0.
REQ-031 SHALL discard a pending result when rst is asserted mid-operation, with no response issued for it.

Configuration
REQ-032 SHALL provide macro ALU_SCHED_CNT_EN; when defined: output port done_cnt, NREQ*16 bits, holds a per-requester count of completed responses (rsp_valid&rsp_ready); counters wrap at 65535->0 and reset to 0.
REQ-033 SHALL, with ALU_SCHED_CNT_EN undefined, omit port done_cnt and all counter logic; all other behaviour SHALL be identical.

Structure
REQ-034 SHALL take the opcode localparams (OP_ADD..OP_AND) and the op_t 3-bit typedef from shared package alu_pkg.
REQ-035 SHALL contain one sub-module, alu_exec: combinational, ports a, b, op -> out, carry, err, implementing REQ-016..018.

Verification
REQ-036 SHALL cover: reset, then req0 ADD a=200 b=100 -> next cycle rsp_valid=1, out=44, carry=1, id=0, err=0.
REQ-037 SHALL cover: req0 SUB 5-9 -> out=252, carry=1; req1 XOR 0xF0^0x3C -> out=0xCC, carry=0.
REQ-038 SHALL cover: both req_valid held high for 4 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1, one result per cycle.
REQ-039 SHALL cover: rsp_ready=0 for 3 cycles -> rsp_* stable, req_ready=0; then rsp_ready=1 -> the next command is accepted in the same cycle.
REQ-040 SHALL cover: op=6 -> out=0, err=1, accepted; rst asserted while in RESP -> rsp_valid=0 next cycle and the next grant goes to requester 0.
REQ-041 SHALL cover, with ALU_SCHED_CNT_EN defined: 3 completions on req1 -> done_cnt slot 1 = 3; a preload of 65535 plus one completion -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, opcode type and scheduler state definitions
package alu_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_ADD = 3'd0;
   localparam op_t OP_SUB = 3'd1;
   localparam op_t OP_XOR = 3'd2;
   localparam op_t OP_OR  = 3'd3;
   localparam op_t OP_AND = 3'd4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } sched_state_t;

endpackage

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - combinational ALU: add/sub/xor/or/and with carry and illegal-opcode flag
module alu_exec
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  op_t          op,
   output logic [W-1:0] out,
   output logic         carry,
   output logic         err
);

   logic [W:0] sum;

   // Decode the opcode; borrow for SUB is the unsigned a<b compare.
   always_comb begin
      out   = '0;
      carry = 1'b0;
      err   = 1'b0;
      sum   = {1'b0, a} + {1'b0, b};
      unique case (op)
         OP_ADD: begin
            out   = sum[W-1:0];
            carry = sum[W];
         end
         OP_SUB: begin
            out   = a - b;
            carry = (a < b);
         end
         OP_XOR: out = a ^ b;
         OP_OR:  out = a | b;
         OP_AND: out = a & b;
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin multi-requester ALU with one-deep response register; ALU_SCHED_CNT_EN adds done_cnt
module alu_sched
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*W-1:0]          req_a,
   input  logic [NREQ*W-1:0]          req_b,
   input  logic [NREQ*3-1:0]          req_op,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NREQ)-1:0]    rsp_id,
   output logic [W-1:0]               rsp_out,
   output logic                       rsp_carry,
   output logic                       rsp_err
`ifdef ALU_SCHED_CNT_EN
   ,
   output logic [NREQ*16-1:0]         done_cnt
`endif
);

   localparam int IDW = $clog2(NREQ);

   sched_state_t   state_q;
   sched_state_t   state_d;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_found;
   logic [IDW:0]   cand_sum;
   logic [IDW-1:0] cand;
   logic           xfer_en;
   logic           xfer;
   logic [W-1:0]   sel_a;
   logic [W-1:0]   sel_b;
   op_t            sel_op;
   logic [W-1:0]   exec_out;
   logic           exec_carry;
   logic           exec_err;

   // The output register can take a new result when empty or when it drains this cycle.
   assign xfer_en   = !rst && ((state_q == ST_IDLE) || rsp_ready);
   assign xfer      = xfer_en && gnt_found;
   assign rsp_valid = (state_q == ST_RESP);

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand_sum  = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_sum = {1'b0, last_grant} + (IDW+1)'(k);
         if (cand_sum >= (IDW+1)'(NREQ)) begin
            cand_sum = cand_sum - (IDW+1)'(NREQ);
         end
         cand = cand_sum[IDW-1:0];
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Route the winner's operands to the execution unit.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = OP_ADD;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            sel_a  = req_a[i*W +: W];
            sel_b  = req_b[i*W +: W];
            sel_op = req_op[i*3 +: 3];
         end
      end
   end

   alu_exec #(.W(W)) u_exec (
      .a     (sel_a),
      .b     (sel_b),
      .op    (sel_op),
      .out   (exec_out),
      .carry (exec_carry),
      .err   (exec_err)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and the one-hot accept for the arbitration winner.
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      if (xfer) begin
         state_d = ST_RESP;
         for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (gnt_idx == IDW'(i));
         end
      end else if ((state_q == ST_RESP) && rsp_ready) begin
         state_d = ST_IDLE;
      end
   end

   // Response register and arbitration pointer; both move only on a transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_out    <= '0;
         rsp_carry  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_id     <= '0;
         last_grant <= IDW'(NREQ-1);
      end else if (xfer) begin
         rsp_out    <= exec_out;
         rsp_carry  <= exec_carry;
         rsp_err    <= exec_err;
         rsp_id     <= gnt_idx;
         last_grant <= gnt_idx;
      end
   end

`ifdef ALU_SCHED_CNT_EN
   logic [NREQ-1:0][15:0] cnt_q;

   assign done_cnt = cnt_q;

   // Count each drained response against the requester that issued it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (rsp_valid && rsp_ready) begin
         cnt_q[rsp_id] <= cnt_q[rsp_id] + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - self-checking bench for alu_sched (ALU_SCHED_CNT_EN exercises done_cnt)
module tb_alu_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [5:0]  req_op;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [0:0]  rsp_id;
   logic [7:0]  rsp_out;
   logic        rsp_carry;
   logic        rsp_err;
`ifdef ALU_SCHED_CNT_EN
   logic [31:0] done_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_sched #(.NREQ(2), .W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_out   (rsp_out),
      .rsp_carry (rsp_carry),
      .rsp_err   (rsp_err)
`ifdef ALU_SCHED_CNT_EN
      ,
      .done_cnt  (done_cnt)
`endif
   );

   typedef struct {
      int         r;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] out;
      logic       c;
      logic       e;
   } vec_t;

   vec_t vt [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Single command from requester r, starting and ending with the output register empty.
   task automatic do_cmd(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eo, input logic ec, input logic ee, input string nm);
      logic [1:0] oh;
      oh = 2'b01 << r;
      @(negedge clk);
      rsp_ready       = 1'b1;
      req_a[r*8 +: 8] = a;
      req_b[r*8 +: 8] = b;
      req_op[r*3 +: 3] = op;
      req_valid       = oh;
      #1;
      chk({nm, ".req_ready"}, 32'(req_ready), 32'(oh));
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, ".rsp_out"},   32'(rsp_out),   32'(eo));
      chk({nm, ".rsp_carry"}, 32'(rsp_carry), 32'(ec));
      chk({nm, ".rsp_err"},   32'(rsp_err),   32'(ee));
      chk({nm, ".rsp_id"},    32'(rsp_id),    32'(r));
      @(posedge clk);
      #1;
      chk({nm, ".drain"}, 32'(rsp_valid), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      vt[0]  = '{0, 3'd0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
      vt[1]  = '{0, 3'd1, 8'd5,   8'd9,   8'd252, 1'b1, 1'b0};
      vt[2]  = '{1, 3'd2, 8'hF0,  8'h3C,  8'hCC,  1'b0, 1'b0};
      vt[3]  = '{1, 3'd3, 8'h0F,  8'hA0,  8'hAF,  1'b0, 1'b0};
      vt[4]  = '{0, 3'd4, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0};
      vt[5]  = '{1, 3'd0, 8'd255, 8'd1,   8'd0,   1'b1, 1'b0};
      vt[6]  = '{0, 3'd1, 8'd9,   8'd5,   8'd4,   1'b0, 1'b0};
      vt[7]  = '{1, 3'd1, 8'd7,   8'd7,   8'd0,   1'b0, 1'b0};
      vt[8]  = '{0, 3'd6, 8'd1,   8'd2,   8'd0,   1'b0, 1'b1};
      vt[9]  = '{1, 3'd5, 8'hFF,  8'hFF,  8'd0,   1'b0, 1'b1};
      vt[10] = '{0, 3'd7, 8'd10,  8'd20,  8'd0,   1'b0, 1'b1};

      rst       = 1'b1;
      req_valid = 2'b11;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b1;

      // Reset state: nothing accepted while rst is high, outputs cleared.
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst.req_ready", 32'(req_ready), 32'd0);
      chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst.rsp_out",   32'(rsp_out),   32'd0);
      chk("rst.rsp_carry", 32'(rsp_carry), 32'd0);
      chk("rst.rsp_err",   32'(rsp_err),   32'd0);
      chk("rst.rsp_id",    32'(rsp_id),    32'd0);
      @(negedge clk);
      req_valid = 2'b00;
      rst       = 1'b0;

      for (int i = 0; i < 11; i++) begin
         do_cmd(vt[i].r, vt[i].op, vt[i].a, vt[i].b, vt[i].out, vt[i].c, vt[i].e,
                $sformatf("vec%0d", i));
      end

      // Both requesters continuously valid: alternate grants, one result per cycle.
      do_reset();
      req_a     = {8'd3, 8'd1};
      req_b     = {8'd4, 8'd1};
      req_op    = {3'd0, 3'd0};
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      #1;
      chk("rr.first_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rr%0d.rsp_valid", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("rr%0d.rsp_id", i),    32'(rsp_id),    32'(i % 2));
         chk($sformatf("rr%0d.rsp_out", i),   32'(rsp_out),   (i % 2 == 1) ? 32'd7 : 32'd2);
         chk($sformatf("rr%0d.req_ready", i), 32'(req_ready), (i % 2 == 0) ? 32'd2 : 32'd1);
      end

      // Consumer stall: response held, nothing accepted; released cycle accepts at once.
      @(negedge clk);
      rsp_ready    = 1'b0;
      req_valid    = 2'b01;
      req_op[2:0]  = 3'd1;
      req_a[7:0]   = 8'd5;
      req_b[7:0]   = 8'd9;
      #1;
      chk("stall.req_ready0", 32'(req_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d.rsp_valid", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("stall%0d.rsp_id", i),    32'(rsp_id),    32'd1);
         chk($sformatf("stall%0d.rsp_out", i),   32'(rsp_out),   32'd7);
         chk($sformatf("stall%0d.rsp_carry", i), 32'(rsp_carry), 32'd0);
         chk($sformatf("stall%0d.req_ready", i), 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk("unstall.req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      chk("unstall.rsp_out",   32'(rsp_out),   32'd252);
      chk("unstall.rsp_carry", 32'(rsp_carry), 32'd1);
      chk("unstall.rsp_id",    32'(rsp_id),    32'd0);
      @(posedge clk);
      #1;
      chk("unstall.drain", 32'(rsp_valid), 32'd0);

      // Reset while a result is pending: result dropped, pointer back to requester 0.
      @(negedge clk);
      req_op[2:0] = 3'd4;
      req_valid   = 2'b01;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      chk("midrst.pending", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst.rsp_out",   32'(rsp_out),   32'd0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 2'b11;
      #1;
      chk("midrst.grant0", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      chk("midrst.rsp_id", 32'(rsp_id), 32'd0);
      @(posedge clk);
      #1;

`ifdef ALU_SCHED_CNT_EN
      do_reset();
      #1;
      chk("cnt.reset", done_cnt, 32'd0);
      for (int i = 0; i < 3; i++) begin
         do_cmd(1, 3'd2, 8'd1, 8'd3, 8'd2, 1'b0, 1'b0, $sformatf("cnt%0d", i));
      end
      chk("cnt.slot1", 32'(done_cnt[31:16]), 32'd3);
      chk("cnt.slot0", 32'(done_cnt[15:0]),  32'd0);
      @(negedge clk);
      force dut.cnt_q = {16'd3, 16'hFFFF};
      #1;
      release dut.cnt_q;
      do_cmd(0, 3'd0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, "cntwrap");
      chk("cnt.wrap0", 32'(done_cnt[15:0]),  32'd0);
      chk("cnt.keep1", 32'(done_cnt[31:16]), 32'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
